// File: rtl/vgpr_wr1_packer.sv
// Collects 1-4 load-return data beats per request and emits one multi-dword wr1 write.
// Optional request validation is compiled in with VGPR_WB_ERROR_CHECK_EN.
module vgpr_wr1_packer (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [9:0]    req_addr,
   input  logic [2:0]    req_count,
   input  logic [63:0]   req_mask,
   input  logic [5:0]    req_tag,
   input  logic          beat_valid,
   output logic          beat_ready,
   input  logic [2047:0] beat_data,
   output logic [63:0]   wr1_en,
   output logic [3:0]    wr1_en_xoutof4,
   output logic [9:0]    wr1_addr,
   output logic [8191:0] wr1_data,
   output logic          done_valid,
   output logic [5:0]    done_tag,
   output logic          err_valid
);

   // Handshake: a transfer happens in any cycle where valid and ready are both high.
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_ERR} state_e;

   state_e        state_q, state_d;
   logic [9:0]    addr_q, addr_d;
   logic [1:0]    cnt_m1_q, cnt_m1_d;
   logic [63:0]   mask_q, mask_d;
   logic [5:0]    tag_q, tag_d;
   logic [1:0]    beat_cnt_q, beat_cnt_d;
   logic [2047:0] slot_q [4];
   logic [2047:0] slot_d [4];
   logic          req_fire;
   logic          beat_fire;
   logic          req_err;

   assign req_fire  = req_valid  & req_ready;
   assign beat_fire = beat_valid & beat_ready;

`ifdef VGPR_WB_ERROR_CHECK_EN
   logic [10:0] end_addr;
   always_comb begin
      end_addr = {1'b0, req_addr} + {8'd0, req_count};
      req_err  = (req_count == 3'd0) || (req_count > 3'd4) || (end_addr > 11'd1024);
   end
`else
   assign req_err = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_m1_d   = cnt_m1_q;
      mask_d     = mask_q;
      tag_d      = tag_q;
      beat_cnt_d = beat_cnt_q;
      for (int k = 0; k < 4; k++) slot_d[k] = slot_q[k];
      case (state_q)
         S_IDLE: begin
            if (req_fire) begin
               addr_d     = req_addr;
               // count-1 mod 4 keeps counts 0 and 5..7 aliasing onto 4 and 1..3
               cnt_m1_d   = req_count[1:0] - 2'd1;
               mask_d     = req_mask;
               tag_d      = req_tag;
               beat_cnt_d = 2'd0;
               for (int k = 0; k < 4; k++) slot_d[k] = '0;
               state_d    = req_err ? S_ERR : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (beat_fire) begin
               slot_d[beat_cnt_q] = beat_data;
               beat_cnt_d         = beat_cnt_q + 2'd1;
               if (beat_cnt_q == cnt_m1_q) state_d = S_WRITE;
            end
         end
         S_WRITE: state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         cnt_m1_q   <= '0;
         mask_q     <= '0;
         tag_q      <= '0;
         beat_cnt_q <= '0;
         for (int k = 0; k < 4; k++) slot_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_m1_q   <= cnt_m1_d;
         mask_q     <= mask_d;
         tag_q      <= tag_d;
         beat_cnt_q <= beat_cnt_d;
         for (int k = 0; k < 4; k++) slot_q[k] <= slot_d[k];
      end
   end

   // Outputs decode from state only; rst gates everything so a reset WRITE never leaks.
   always_comb begin
      req_ready      = 1'b0;
      beat_ready     = 1'b0;
      wr1_en         = '0;
      wr1_en_xoutof4 = '0;
      wr1_addr       = '0;
      wr1_data       = '0;
      done_valid     = 1'b0;
      done_tag       = '0;
      err_valid      = 1'b0;
      if (!rst) begin
         case (state_q)
            S_IDLE:    req_ready  = 1'b1;
            S_COLLECT: beat_ready = 1'b1;
            S_WRITE: begin
               wr1_en   = mask_q;
               wr1_addr = addr_q;
               case (cnt_m1_q)
                  2'd0:    wr1_en_xoutof4 = 4'h1;
                  2'd1:    wr1_en_xoutof4 = 4'h3;
                  2'd2:    wr1_en_xoutof4 = 4'h7;
                  default: wr1_en_xoutof4 = 4'hF;
               endcase
               for (int i = 0; i < 64; i++)
                  for (int j = 0; j < 4; j++)
                     wr1_data[128*i+32*j +: 32] = slot_q[j][32*i +: 32];
               done_valid = 1'b1;
               done_tag   = tag_q;
            end
`ifdef VGPR_WB_ERROR_CHECK_EN
            S_ERR: begin
               err_valid = 1'b1;
               done_tag  = tag_q;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vgpr_wr1_packer.sv
// Directed + randomized bench for vgpr_wr1_packer with a transaction-level reference model.
module tb_vgpr_wr1_packer;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [9:0]    req_addr;
  logic [2:0]    req_count;
  logic [63:0]   req_mask;
  logic [5:0]    req_tag;
  logic          beat_valid;
  logic          beat_ready;
  logic [2047:0] beat_data;
  logic [63:0]   wr1_en;
  logic [3:0]    wr1_en_xoutof4;
  logic [9:0]    wr1_addr;
  logic [8191:0] wr1_data;
  logic          done_valid;
  logic [5:0]    done_tag;
  logic          err_valid;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2047:0] beats [4];

  vgpr_wr1_packer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_count(req_count), .req_mask(req_mask), .req_tag(req_tag),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
    .wr1_en(wr1_en), .wr1_en_xoutof4(wr1_en_xoutof4), .wr1_addr(wr1_addr),
    .wr1_data(wr1_data), .done_valid(done_valid), .done_tag(done_tag),
    .err_valid(err_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beats();
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 64; w++) beats[k][32*w +: 32] = $urandom;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wr1_en"}, wr1_en, 64'd0);
    chk({tag, "_xoutof4"}, {60'd0, wr1_en_xoutof4}, 64'd0);
    chk({tag, "_wr1_addr"}, {54'd0, wr1_addr}, 64'd0);
    chk({tag, "_data_zero"}, {63'd0, (wr1_data == '0)}, 64'd1);
    chk({tag, "_done"}, {63'd0, done_valid}, 64'd0);
    chk({tag, "_err"}, {63'd0, err_valid}, 64'd0);
  endtask

  // One full request: accept, n beats (with gap idle cycles before each), WRITE, back to IDLE.
  task automatic do_txn(input logic [9:0] a, input logic [2:0] c, input logic [63:0] m,
                        input logic [5:0] t, input int gap, input bit hold_next,
                        input logic [9:0] na, input logic [2:0] nc, input logic [63:0] nm,
                        input logic [5:0] nt);
    int n;
    logic [31:0] exp_dw;
    n = ((int'(c) + 3) % 4) + 1;
    req_valid = 1'b1; req_addr = a; req_count = c; req_mask = m; req_tag = t;
    #1;
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    chk("beat_ready_idle", {63'd0, beat_ready}, 64'd0);
    step();
    if (hold_next) begin
      req_addr = na; req_count = nc; req_mask = nm; req_tag = nt;
    end else begin
      req_valid = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gap; g++) begin
        beat_valid = 1'b0;
        #1;
        chk("gap_beat_ready", {63'd0, beat_ready}, 64'd1);
        chk("gap_req_ready", {63'd0, req_ready}, 64'd0);
        chk("gap_done", {63'd0, done_valid}, 64'd0);
        step();
      end
      beat_valid = 1'b1;
      beat_data  = beats[k];
      #1;
      chk("collect_beat_ready", {63'd0, beat_ready}, 64'd1);
      chk("collect_req_ready", {63'd0, req_ready}, 64'd0);
      chk("collect_wr1_en", wr1_en, 64'd0);
      step();
    end
    beat_valid = 1'b0;
    for (int w = 0; w < 64; w++) beat_data[32*w +: 32] = $urandom;
    #1;
    chk("write_wr1_en", wr1_en, m);
    chk("write_xoutof4", {60'd0, wr1_en_xoutof4}, (64'd1 << n) - 64'd1);
    chk("write_addr", {54'd0, wr1_addr}, {54'd0, a});
    chk("write_done", {63'd0, done_valid}, 64'd1);
    chk("write_tag", {58'd0, done_tag}, {58'd0, t});
    chk("write_err", {63'd0, err_valid}, 64'd0);
    chk("write_beat_ready", {63'd0, beat_ready}, 64'd0);
    chk("write_req_ready", {63'd0, req_ready}, 64'd0);
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 4; j++) begin
        exp_dw = (j < n) ? beats[j][32*i +: 32] : 32'd0;
        chk($sformatf("write_data_l%0d_d%0d", i, j), {32'd0, wr1_data[128*i+32*j +: 32]},
            {32'd0, exp_dw});
      end
    step();
    #1;
    chk_quiet("post_write");
    chk("post_write_req_ready", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic do_simple(input logic [9:0] a, input logic [2:0] c, input logic [63:0] m,
                           input logic [5:0] t, input int gap);
    do_txn(a, c, m, t, gap, 1'b0, 10'd0, 3'd0, 64'd0, 6'd0);
  endtask

`ifdef VGPR_WB_ERROR_CHECK_EN
  task automatic do_err(input logic [9:0] a, input logic [2:0] c, input logic [5:0] t);
    req_valid = 1'b1; req_addr = a; req_count = c; req_mask = '1; req_tag = t;
    beat_valid = 1'b1;
    #1;
    chk("err_req_ready", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
    #1;
    chk("err_pulse", {63'd0, err_valid}, 64'd1);
    chk("err_done_valid", {63'd0, done_valid}, 64'd0);
    chk("err_tag", {58'd0, done_tag}, {58'd0, t});
    chk("err_wr1_en", wr1_en, 64'd0);
    chk("err_beat_ready", {63'd0, beat_ready}, 64'd0);
    step();
    #1;
    chk("err_after_beat_ready", {63'd0, beat_ready}, 64'd0);
    chk_quiet("err_after");
    beat_valid = 1'b0;
  endtask
`endif

  initial begin
    logic [9:0]  ra;
    logic [2:0]  rc;
    logic [63:0] rm;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_count = '0; req_mask = '0;
    req_tag = '0; beat_valid = 1'b0; beat_data = '0;
    step(); step();
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_beat_ready", {63'd0, beat_ready}, 64'd0);
    chk_quiet("rst");
    rst = 1'b0;
    #1;
    chk("idle_req_ready", {63'd0, req_ready}, 64'd1);

    // Beat offered in IDLE must be ignored.
    beat_valid = 1'b1; beat_data = '1;
    #1;
    chk("idle_beat_ready", {63'd0, beat_ready}, 64'd0);
    step();
    beat_valid = 1'b0;

    // Count 4, lane<<8|k pattern.
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 64; i++) beats[k][32*i +: 32] = (i << 8) | k;
    do_simple(10'h010, 3'd4, '1, 6'h2A, 0);

    // Count 1 with single lane.
    rand_beats();
    beats[0][31:0] = 32'hDEADBEEF;
    do_simple(10'h155, 3'd1, 64'h1, 6'h05, 0);

    // Count 2, beats every other cycle, next request held valid throughout.
    rand_beats();
    do_txn(10'h200, 3'd2, 64'hF0F0_1234_5678_9ABC, 6'h11, 1, 1'b1,
           10'h3FF, 3'd3, 64'h8000_0000_0000_0001, 6'h12);
    rand_beats();
    do_simple(10'h3FF, 3'd3, 64'h8000_0000_0000_0001, 6'h12, 0);

    // Reset after 2 of 3 beats discards the request.
    rand_beats();
    req_valid = 1'b1; req_addr = 10'h040; req_count = 3'd3; req_mask = '1; req_tag = 6'h33;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      beat_valid = 1'b1; beat_data = beats[k];
      step();
    end
    beat_valid = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("midrst_beat_ready", {63'd0, beat_ready}, 64'd0);
    chk_quiet("midrst");
    step();
    rst = 1'b0;
    #1;
    chk_quiet("midrst_after");
    chk("midrst_after_beat_ready", {63'd0, beat_ready}, 64'd0);
    rand_beats();
    do_simple(10'h041, 3'd3, 64'h0123_4567_89AB_CDEF, 6'h34, 0);

    // Reset asserted in the WRITE cycle forces wr1/done quiet.
    rand_beats();
    req_valid = 1'b1; req_addr = 10'h077; req_count = 3'd1; req_mask = '1; req_tag = 6'h3C;
    step();
    req_valid = 1'b0; beat_valid = 1'b1; beat_data = beats[0];
    step();
    beat_valid = 1'b0; rst = 1'b1;
    #1;
    chk_quiet("wrrst");
    step();
    rst = 1'b0;
    #1;
    chk_quiet("wrrst_after");

    // Mask 0 still writes and completes.
    rand_beats();
    do_simple(10'h123, 3'd3, 64'd0, 6'h0F, 0);

`ifdef VGPR_WB_ERROR_CHECK_EN
    do_err(10'h100, 3'd0, 6'h21);
    do_err(10'h3FE, 3'd4, 6'h22);
    do_err(10'h000, 3'd6, 6'h23);
    rand_beats();
    do_simple(10'h3FC, 3'd4, '1, 6'h24, 0);
`else
    rand_beats();
    do_simple(10'h3FE, 3'd0, '1, 6'h21, 0);
    rand_beats();
    do_simple(10'h050, 3'd6, 64'hAAAA_5555_AAAA_5555, 6'h22, 0);
`endif

    // Randomized requests.
    for (int r = 0; r < 20; r++) begin
      rand_beats();
      rm = {$urandom, $urandom};
`ifdef VGPR_WB_ERROR_CHECK_EN
      rc = 3'($urandom_range(1, 4));
      ra = 10'($urandom_range(0, 1024 - int'(rc)));
`else
      rc = 3'($urandom_range(0, 7));
      ra = 10'($urandom_range(0, 1023));
`endif
      do_simple(ra, rc, rm, 6'($urandom_range(0, 63)), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vgpr_wr1_packer.md
# vgpr_wr1_packer

Write-back packer for the 64-lane vector register file's multi-dword write port (wr1). It accepts a load-return request with a base VGPR, a dword count of 1–4 and an exec mask. It then collects one 2048-bit data beat per dword (one 32-bit dword per lane) and issues one single-cycle wr1 write carrying all dwords. The block sits between the LSU return path and the VGPR file.

## Interface
Parameters:
- none; geometry is fixed at 64 lanes, 4 dword slots and 10-bit VGPR address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_addr  in  10  base VGPR address.
- req_count  in  3  dword count; legal values are 1..4.
- req_mask  in  64  lane exec mask.
- req_tag  in  6  opaque tag, returned on done.
- beat_valid  in  1  data beat present.
- beat_ready  out  1  high only in COLLECT.
- beat_data  in  2048  lane i dword at [32i+31:32i].
- wr1_en  out  64  per-lane write enable.
- wr1_en_xoutof4  out  4  bit j writes VGPR wr1_addr+j.
- wr1_addr  out  10  base VGPR.
- wr1_data  out  8192  lane i, dword j at [128i+32j+31:128i+32j].
- done_valid  out  1  one-cycle pulse per completed request.
- done_tag  out  6  tag of the completed request.
- err_valid  out  1  one-cycle error pulse; stuck at 0 unless the error-check feature is compiled in.

## Operation
- Handshakes: a transfer occurs when valid&ready are high in the same cycle. The block never stalls on wr1; wr1 has no backpressure.
- IDLE
  - req_ready=1.
  - On a request transfer: latch addr, count, mask and tag; clear all 4 slots to 0; beat_cnt=0; go to COLLECT.
- COLLECT
  - beat_ready=1.
  - On a beat transfer: slot[beat_cnt] <= beat_data; beat_cnt++.
  - The beat at beat_cnt==count_eff-1 moves the block to WRITE.
- WRITE (one cycle)
  - wr1_en=mask; wr1_en_xoutof4=(1<<count_eff)-1; wr1_addr=addr.
  - wr1_data interleaves the slots per lane.
  - done_valid=1, done_tag=tag.
  - Next state is IDLE.
- wr1_en, wr1_en_xoutof4, wr1_addr, wr1_data and done_* are all 0 outside WRITE.
- Effective count without the error-check feature: count_eff = ((req_count-1) mod 4)+1, so 0→4, 5→1, 6→2, 7→3.
- A mask of 0 still performs the WRITE cycle (wr1_en=0) and pulses done.
- Address wrap: addr+j wraps modulo 1024; the register file handles this and the block does nothing special.
- Slots beyond count_eff stay 0 in wr1_data.

## Timing
- Reset: state=IDLE; req_ready=0 and beat_ready=0 while rst is high; every other output is 0; slots and beat_cnt are cleared.
- Latency: request accepted in cycle T, beats in T+1..T+N, WRITE/done in the cycle after the last beat.
- Minimum occupancy is N+2 cycles per request.
- Beats presented while in IDLE or WRITE are not accepted (beat_ready=0).
- A request presented in COLLECT or WRITE waits (req_ready=0).
- Reset mid-COLLECT or in WRITE: partial data is discarded and no wr1 write or done is issued. If rst is high in a WRITE cycle, all wr1_* outputs are forced to 0.

## Configuration
- VGPR_WB_ERROR_CHECK_EN defined:
  - A request is in error if req_count is 0, req_count >4, or req_addr+req_count >1024.
  - An erroring request is accepted, then the next cycle pulses err_valid=1 with done_tag=tag and done_valid=0.
  - No beats are consumed, no wr1 write is issued, and the block returns to IDLE.
- Undefined:
  - err_valid is tied to 0.
  - count_eff is computed as described under Operation.
  - Addresses wrap.

## Test plan
- Count 4, addr 0x010, mask all-ones, beats of dword value (lane<<8|k) for k=0..3 → one WRITE with xoutof4=4'hF, wr1_addr=0x010, lane 5 dword 2 = 0x0502; done_tag matches.
- Count 1, mask 0x1, beat 0xDEADBEEF in lane 0 → xoutof4=4'h1, wr1_en=64'h1, wr1_data[31:0]=0xDEADBEEF, dwords 1–3 zero.
- Count 2 with beat_valid toggling every other cycle; a second request held valid throughout → req_ready=0 until after WRITE, no beat lost, the second request is accepted in the cycle after done.
- Assert rst after 2 of 3 beats → no wr1_en activity and no done; after reset a fresh count-3 request completes normally.
- Mask 0 with count 3 → WRITE cycle with wr1_en=0 and xoutof4=4'h7, done pulses.
- With VGPR_WB_ERROR_CHECK_EN, count 0 or addr 0x3FE with count 4 → err_valid pulse, no wr1 write, beat_ready never asserted. Without the macro, count 0 → xoutof4=4'hF.
